// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap-index helper for the convolution MAC PE.
package conv_pkg;

    localparam int FILT_SIZE  = 3;
    localparam int FILT_TAPS  = 9;
    localparam int ROW_PIXELS = 5;

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2
    } pe_state_t;

    // Row-major weight index of filter tap (row r, column k).
    function automatic logic [3:0] tap_index(input logic [1:0] r, input logic [1:0] k);
        return ({2'b00, r} << 1) + {2'b00, r} + {2'b00, k};
    endfunction

endpackage

// File: rtl/conv_mac_dp.sv
// Datapath of the convolution PE: 3x3 weight register file, pixel*weight product
// and the three column partial-sum accumulators.
module conv_mac_dp
    import conv_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int WWIDTH = 8,
    parameter int OWIDTH = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wt_we_i,
    input  logic [3:0]        wt_idx_i,
    input  logic [WWIDTH-1:0] wt_data_i,
    input  logic              acc_en_i,
    input  logic              clr_i,
    input  logic [DWIDTH-1:0] pix_i,
    input  logic [1:0]        k_i,
    input  logic [1:0]        w_i,
    input  logic [1:0]        r_i,
    output logic [OWIDTH-1:0] psum0_o,
    output logic [OWIDTH-1:0] psum1_o,
    output logic [OWIDTH-1:0] psum2_o
);

    localparam int PW = DWIDTH + WWIDTH + 1;

    logic signed [WWIDTH-1:0] wt_q   [FILT_TAPS];
    logic signed [OWIDTH-1:0] psum_q [FILT_SIZE];
    logic        [3:0]        tap_s;
    logic signed [PW-1:0]     pix_ext_s;
    logic signed [PW-1:0]     wt_ext_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [OWIDTH-1:0] prod_ext_s;

    // Pixel is unsigned, so zero-extend it; the weight is sign-extended. The
    // product always fits in PW bits, so the truncated multiply is exact.
    assign tap_s      = tap_index(r_i, k_i);
    assign pix_ext_s  = {{WWIDTH{1'b0}}, pix_i};
    assign wt_ext_s   = {{(DWIDTH + 1){wt_q[tap_s][WWIDTH-1]}}, wt_q[tap_s]};
    assign prod_s     = pix_ext_s * wt_ext_s;
    assign prod_ext_s = {{(OWIDTH - PW){prod_s[PW-1]}}, prod_s};

    // Weight register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FILT_TAPS; i++) begin
                wt_q[i] <= '0;
            end
        end else if (wt_we_i) begin
            wt_q[wt_idx_i] <= wt_data_i;
        end
    end

    // Column accumulators: clear after drain, otherwise fold the product into column w.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FILT_SIZE; i++) begin
                psum_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < FILT_SIZE; i++) begin
                psum_q[i] <= '0;
            end
        end else if (acc_en_i) begin
            psum_q[w_i] <= psum_q[w_i] + prod_ext_s;
        end
    end

    assign psum0_o = psum_q[0];
    assign psum1_o = psum_q[1];
    assign psum2_o = psum_q[2];

endmodule

// File: rtl/conv_mac_pe.sv
// 3x3 convolution MAC PE: loads 9 weights, accumulates 27 streamed pixels into
// three column sums, then drains them in column order with a valid/ready handshake.
module conv_mac_pe #(
    parameter int DWIDTH = 8,
    parameter int WWIDTH = 8,
    parameter int OWIDTH = 21,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WWIDTH-1:0] wt_data,
    input  logic              wt_valid,
    output logic              wt_ready,
    input  logic [DWIDTH-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [OWIDTH-1:0] psum_data,
    output logic [1:0]        psum_col,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic [CWIDTH-1:0] grp_cnt,
    output logic              busy
);
    import conv_pkg::*;

    generate
        if (OWIDTH < DWIDTH + WWIDTH + 5) begin : g_owidth_chk
            $error("conv_mac_pe: OWIDTH must be at least DWIDTH+WWIDTH+5");
        end
    endgenerate

    pe_state_t         state_q, state_d;
    logic [3:0]        widx_q, widx_d;
    logic [1:0]        k_q, k_d, w_q, w_d, r_q, r_d, c_q, c_d;
    logic [CWIDTH-1:0] grp_q, grp_d;
    logic [OWIDTH-1:0] hold_q, hold_d;
    logic              wt_ready_s, pix_ready_s, wt_we_s, acc_en_s, clr_s, boundary_s;
    logic [3:0]        wt_idx_s;
    logic [OWIDTH-1:0] psum0_s, psum1_s, psum2_s;

    assign boundary_s = (k_q == 2'd0) && (w_q == 2'd0) && (r_q == 2'd0);

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        k_d         = k_q;
        w_d         = w_q;
        r_d         = r_q;
        c_d         = c_q;
        grp_d       = grp_q;
        hold_d      = hold_q;
        wt_ready_s  = 1'b0;
        pix_ready_s = 1'b0;
        wt_we_s     = 1'b0;
        wt_idx_s    = widx_q;
        acc_en_s    = 1'b0;
        clr_s       = 1'b0;
        case (state_q)
            LOAD_W: begin
                wt_ready_s = 1'b1;
                if (wt_valid) begin
                    wt_we_s = 1'b1;
                    if (widx_q == 4'd8) begin
                        widx_d  = 4'd0;
                        state_d = RUN;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end else begin
                    widx_d = widx_q;
                end
            end
            RUN: begin
                // A weight offered at a group boundary starts a reload and beats any pixel.
                if (boundary_s && wt_valid) begin
                    wt_ready_s = 1'b1;
                    wt_we_s    = 1'b1;
                    wt_idx_s   = 4'd0;
                    widx_d     = 4'd1;
                    state_d    = LOAD_W;
                end else begin
                    pix_ready_s = 1'b1;
                    if (pix_valid) begin
                        acc_en_s = 1'b1;
                        if (k_q == 2'd2) begin
                            k_d = 2'd0;
                            if (w_q == 2'd2) begin
                                w_d = 2'd0;
                                if (r_q == 2'd2) begin
                                    r_d     = 2'd0;
                                    c_d     = 2'd0;
                                    hold_d  = psum0_s;
                                    state_d = DRAIN;
                                end else begin
                                    r_d = r_q + 2'd1;
                                end
                            end else begin
                                w_d = w_q + 2'd1;
                            end
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end else begin
                        acc_en_s = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (psum_ready) begin
                    case (c_q)
                        2'd0: begin
                            c_d    = 2'd1;
                            hold_d = psum1_s;
                        end
                        2'd1: begin
                            c_d    = 2'd2;
                            hold_d = psum2_s;
                        end
                        default: begin
                            c_d     = 2'd0;
                            clr_s   = 1'b1;
                            grp_d   = grp_q + CWIDTH'(1);
                            state_d = RUN;
                        end
                    endcase
                end else begin
                    c_d = c_q;
                end
            end
            default: begin
                state_d = LOAD_W;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_W;
            widx_q  <= 4'd0;
            k_q     <= 2'd0;
            w_q     <= 2'd0;
            r_q     <= 2'd0;
            c_q     <= 2'd0;
            grp_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            k_q     <= k_d;
            w_q     <= w_d;
            r_q     <= r_d;
            c_q     <= c_d;
            grp_q   <= grp_d;
            hold_q  <= hold_d;
        end
    end

    conv_mac_dp #(
        .DWIDTH(DWIDTH),
        .WWIDTH(WWIDTH),
        .OWIDTH(OWIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .wt_we_i  (wt_we_s),
        .wt_idx_i (wt_idx_s),
        .wt_data_i(wt_data),
        .acc_en_i (acc_en_s),
        .clr_i    (clr_s),
        .pix_i    (pix_data),
        .k_i      (k_q),
        .w_i      (w_q),
        .r_i      (r_q),
        .psum0_o  (psum0_s),
        .psum1_o  (psum1_s),
        .psum2_o  (psum2_s)
    );

    // Readies and busy are forced low while reset is held.
    assign wt_ready   = rst_n & wt_ready_s;
    assign pix_ready  = rst_n & pix_ready_s;
    assign busy       = rst_n & ~((state_q == RUN) && boundary_s);
    assign psum_valid = (state_q == DRAIN);
    assign psum_data  = hold_q;
    assign psum_col   = c_q;
    assign grp_cnt    = grp_q;

endmodule
